// File: rtl/scoreboard_pkg.sv
// ============================================================================
//  scoreboard_pkg : shared defaults and types for index_decoder_scoreboard
//  Revision: 1.0
// ============================================================================
`default_nettype none

package scoreboard_pkg;

  localparam int WIDTH_DEFAULT   = 64;
  localparam int NUM_SET_DEFAULT = 2;
  localparam int IDX_W           = $clog2(WIDTH_DEFAULT);
  localparam int CNT_W           = $clog2(WIDTH_DEFAULT + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

`default_nettype wire

// File: rtl/onehot_decoder.sv
// ============================================================================
//  onehot_decoder : index -> one-hot vector with out-of-range detection
//  Revision: 1.0
// ============================================================================
`default_nettype none

module onehot_decoder
  import scoreboard_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [WIDTH-1:0] onehot,
  output logic             oor
);

  localparam logic [IDX_W:0] c_limit = (IDX_W + 1)'(WIDTH);

  // Out-of-range indices decode to all zeros so they never touch the map.
  always_comb begin
    onehot = '0;
    oor    = 1'b0;
    if (en) begin
      if ({1'b0, idx} < c_limit) begin
        onehot[idx] = 1'b1;
      end else begin
        oor = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/index_decoder_scoreboard.sv
// ============================================================================
//  index_decoder_scoreboard : registered set/clear bitmap with popcount
//  Optional duplicate-operation checking: SCOREBOARD_DUP_CHECK_EN
//  Revision: 1.0
// ============================================================================
`default_nettype none

module index_decoder_scoreboard
  import scoreboard_pkg::*;
#(
  parameter  int WIDTH         = WIDTH_DEFAULT,
  parameter  int NUM_SET       = NUM_SET_DEFAULT,
  parameter  bit RESET_ALL_SET = 1'b0,
  localparam int IDX_W         = $clog2(WIDTH),
  localparam int CNT_W         = $clog2(WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SET-1:0]       set_valid,
  input  logic [NUM_SET*IDX_W-1:0] set_idx,
  input  logic                     clr_valid,
  input  logic [IDX_W-1:0]         clr_idx,
  input  logic                     flush,
  input  logic [IDX_W-1:0]         lookup_idx,
  output logic                     lookup_hit,
  output logic [WIDTH-1:0]         mask,
  output logic [CNT_W-1:0]         count,
  output logic                     err_range,
  output logic                     err_dup
);

  localparam logic [WIDTH-1:0] c_rst_mask  = {WIDTH{RESET_ALL_SET}};
  localparam logic [CNT_W-1:0] c_rst_count = RESET_ALL_SET ? CNT_W'(WIDTH) : '0;
  localparam logic [IDX_W:0]   c_limit     = (IDX_W + 1)'(WIDTH);

  logic [WIDTH-1:0]   set_oh [NUM_SET];
  logic [NUM_SET-1:0] set_oor;
  logic [WIDTH-1:0]   clr_oh;
  logic               clr_oor;

  logic [WIDTH-1:0]   mask_q, mask_d, set_any;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_range_q, err_range_d;

  for (genvar k = 0; k < NUM_SET; k++) begin : g_set_dec
    onehot_decoder #(.WIDTH(WIDTH)) u_set_dec (
      .idx    (set_idx[k*IDX_W +: IDX_W]),
      .en     (set_valid[k]),
      .onehot (set_oh[k]),
      .oor    (set_oor[k])
    );
  end

  onehot_decoder #(.WIDTH(WIDTH)) u_clr_dec (
    .idx    (clr_idx),
    .en     (clr_valid),
    .onehot (clr_oh),
    .oor    (clr_oor)
  );

  // Clear before set so a same-cycle set of the same index wins; flush overrides all.
  always_comb begin
    set_any = '0;
    for (int k = 0; k < NUM_SET; k++) begin
      set_any = set_any | set_oh[k];
    end
    mask_d      = flush ? c_rst_mask : ((mask_q & ~clr_oh) | set_any);
    err_range_d = err_range_q | (|set_oor) | clr_oor;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_d = count_d + CNT_W'(mask_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q      <= c_rst_mask;
      count_q     <= c_rst_count;
      err_range_q <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      count_q     <= count_d;
      err_range_q <= err_range_d;
    end
  end

`ifdef SCOREBOARD_DUP_CHECK_EN
  logic err_dup_q, err_dup_d;
  logic dup_evt;

  // Checked against the registered map; out-of-range requests decode to zero and never match.
  always_comb begin
    dup_evt = 1'b0;
    if (!flush) begin
      for (int k = 0; k < NUM_SET; k++) begin
        if (|(set_oh[k] & mask_q)) dup_evt = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (|(set_oh[k] & set_oh[j])) dup_evt = 1'b1;
        end
      end
      if (clr_valid && !clr_oor && !(|(clr_oh & mask_q))) dup_evt = 1'b1;
    end
    err_dup_d = err_dup_q | dup_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_dup_q <= 1'b0;
    end else begin
      err_dup_q <= err_dup_d;
    end
  end

  assign err_dup = err_dup_q;
`else
  assign err_dup = 1'b0;
`endif

  assign mask       = mask_q;
  assign count      = count_q;
  assign err_range  = err_range_q;
  assign lookup_hit = ({1'b0, lookup_idx} < c_limit) ? mask_q[lookup_idx] : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_index_decoder_scoreboard.sv
// ============================================================================
//  tb_index_decoder_scoreboard : directed bench with rule-level reference model
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_index_decoder_scoreboard;
  import scoreboard_pkg::*;

`ifdef SCOREBOARD_DUP_CHECK_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  set_valid;
  logic [11:0] set_idx;
  logic        clr_valid;
  idx_t        clr_idx;
  logic        flush;
  idx_t        lookup_idx;

  logic [63:0] mask_a;  logic [6:0] count_a;  logic hit_a, er_a, ed_a;
  logic [47:0] mask_b;  logic [5:0] count_b;  logic hit_b, er_b, ed_b;

  always #5 clk = ~clk;

  index_decoder_scoreboard #(.WIDTH(64), .NUM_SET(2), .RESET_ALL_SET(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .set_valid(set_valid), .set_idx(set_idx),
    .clr_valid(clr_valid), .clr_idx(clr_idx), .flush(flush), .lookup_idx(lookup_idx),
    .lookup_hit(hit_a), .mask(mask_a), .count(count_a), .err_range(er_a), .err_dup(ed_a)
  );

  index_decoder_scoreboard #(.WIDTH(48), .NUM_SET(2), .RESET_ALL_SET(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .set_valid(set_valid), .set_idx(set_idx),
    .clr_valid(clr_valid), .clr_idx(clr_idx), .flush(flush), .lookup_idx(lookup_idx),
    .lookup_hit(hit_b), .mask(mask_b), .count(count_b), .err_range(er_b), .err_dup(ed_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one step of the map for a table of width w, applied rule by rule.
  function automatic logic [63:0] model_next(input int w, input logic [63:0] m, input bit all_ones,
                                             output bit oor, output bit dup);
    logic [63:0] n, full;
    int idx0, idx1;
    full = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    n = m; oor = 0; dup = 0;
    idx0 = int'(set_idx[5:0]);
    idx1 = int'(set_idx[11:6]);
    if (clr_valid) begin
      if (int'(clr_idx) < w) begin
        if (!m[clr_idx]) dup = 1;
        n[clr_idx] = 1'b0;
      end else oor = 1;
    end
    for (int k = 0; k < 2; k++) begin
      int ix;
      ix = (k == 0) ? idx0 : idx1;
      if (set_valid[k]) begin
        if (ix < w) begin
          if (m[ix]) dup = 1;
          n[ix] = 1'b1;
        end else oor = 1;
      end
    end
    if (set_valid == 2'b11 && idx0 == idx1 && idx0 < w) dup = 1;
    if (flush) begin
      n = all_ones ? full : 64'd0;
      dup = 0;
    end
    return n;
  endfunction

  logic [63:0] m_a, m_b, nx_a, nx_b;
  bit mer_a, med_a, mer_b, med_b;
  bit oor_a, dup_a, oor_b, dup_b;

  always_comb begin
    nx_a = model_next(64, m_a, 1'b0, oor_a, dup_a);
    nx_b = model_next(48, m_b, 1'b1, oor_b, dup_b);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= 64'd0;  m_b <= 64'h0000_FFFF_FFFF_FFFF;
      mer_a <= 0; med_a <= 0; mer_b <= 0; med_b <= 0;
    end else begin
      m_a <= nx_a;  m_b <= nx_b;
      mer_a <= mer_a | oor_a;  mer_b <= mer_b | oor_b;
      med_a <= med_a | (DUP_EN & dup_a);
      med_b <= med_b | (DUP_EN & dup_b);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("mask_a",  mask_a,  m_a);
    check("count_a", 64'(count_a), 64'($countones(m_a)));
    check("hit_a",   64'(hit_a), 64'(m_a[lookup_idx]));
    check("err_range_a", 64'(er_a), 64'(mer_a));
    check("err_dup_a",   64'(ed_a), 64'(med_a));
    check("mask_b",  64'(mask_b), m_b);
    check("count_b", 64'(count_b), 64'($countones(m_b)));
    check("hit_b",   64'(hit_b), (int'(lookup_idx) < 48) ? 64'(m_b[lookup_idx]) : 64'd0);
    check("err_range_b", 64'(er_b), 64'(mer_b));
    check("err_dup_b",   64'(ed_b), 64'(med_b));
  end

  typedef struct packed {
    logic [1:0]  sv;
    logic [11:0] si;
    logic        cv;
    logic [5:0]  ci;
    logic        fl;
    logic [5:0]  lk;
  } vec_t;

  vec_t vecs [8] = '{
    '{2'b11, {6'd47, 6'd48}, 1'b0, 6'd0,  1'b0, 6'd47},
    '{2'b01, {6'd0,  6'd0},  1'b1, 6'd47, 1'b0, 6'd0},
    '{2'b10, {6'd63, 6'd0},  1'b1, 6'd48, 1'b0, 6'd63},
    '{2'b00, 12'd0,          1'b1, 6'd63, 1'b0, 6'd63},
    '{2'b11, {6'd20, 6'd21}, 1'b1, 6'd0,  1'b0, 6'd21},
    '{2'b00, 12'd0,          1'b0, 6'd0,  1'b0, 6'd20},
    '{2'b11, {6'd30, 6'd30}, 1'b1, 6'd20, 1'b1, 6'd30},
    '{2'b00, 12'd0,          1'b0, 6'd0,  1'b0, 6'd1}
  };

  localparam logic [63:0] ONES48 = 64'h0000_FFFF_FFFF_FFFF;

  task automatic idle();
    set_valid = 2'b00; clr_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; idle(); set_idx = '0; clr_idx = '0; lookup_idx = '0;
    tick(); tick();
    check("rst_mask_a",  mask_a, 64'd0);
    check("rst_count_a", 64'(count_a), 64'd0);
    check("rst_mask_b",  64'(mask_b), ONES48);
    check("rst_count_b", 64'(count_b), 64'd48);
    rst_n = 1'b1;

    lookup_idx = 6'd63; set_valid = 2'b11; set_idx = {6'd5, 6'd63};
    #1 check("hit_before_edge", 64'(hit_a), 64'd0);
    tick(); idle();
    check("set2_mask_a",  mask_a, 64'h8000_0000_0000_0020);
    check("set2_count_a", 64'(count_a), 64'd2);
    check("set2_hit_a",   64'(hit_a), 64'd1);
    check("oor63_err_b",  64'(er_b), 64'd1);
    check("oor63_mask_b", 64'(mask_b), ONES48);

    set_valid = 2'b01; set_idx = {6'd0, 6'd7}; clr_valid = 1'b1; clr_idx = 6'd7;
    tick(); idle();
    check("set_wins_mask_a", mask_a, 64'h8000_0000_0000_00A0);
    clr_valid = 1'b1; clr_idx = 6'd7;
    tick(); idle();
    check("clr7_mask_a",  mask_a, 64'h8000_0000_0000_0020);
    check("clr7_count_a", 64'(count_a), 64'd2);

    set_valid = 2'b11; set_idx = {6'd2, 6'd1}; tick();
    set_valid = 2'b01; set_idx = {6'd0, 6'd3}; tick(); idle();
    check("pre_flush_count_a", 64'(count_a), 64'd5);
    flush = 1'b1; set_valid = 2'b01; set_idx = {6'd0, 6'd9};
    tick(); idle();
    check("flush_mask_a",  mask_a, 64'd0);
    check("flush_count_a", 64'(count_a), 64'd0);
    check("flush_keeps_err_b", 64'(er_b), 64'd1);
    check("flush_mask_b",  64'(mask_b), ONES48);

    set_valid = 2'b01; set_idx = {6'd0, 6'd50}; rst_n = 1'b0;
    tick();
    check("rst_clears_err_b", 64'(er_b), 64'd0);
    check("rst_drops_req_a",  mask_a, 64'd0);
    rst_n = 1'b1; idle();

    clr_valid = 1'b1; clr_idx = 6'd50; tick(); idle();
    check("clr50_err_b",  64'(er_b), 64'd1);
    check("clr50_mask_b", 64'(mask_b), ONES48);
    check("clr50_err_a",  64'(er_a), 64'd0);
    flush = 1'b1; tick(); idle();
    check("err_b_through_flush", 64'(er_b), 64'd1);

    rst_n = 1'b0; tick(); rst_n = 1'b1;
    set_valid = 2'b01; set_idx = {6'd0, 6'd50}; tick(); idle();
    check("set50_err_b",  64'(er_b), 64'd1);
    check("set50_mask_a", mask_a, 64'h0004_0000_0000_0000);

    rst_n = 1'b0; tick(); rst_n = 1'b1;
    set_valid = 2'b01; set_idx = {6'd0, 6'd4}; tick();
    check("dup_first_a", 64'(ed_a), 64'd0);
    tick(); idle();
    check("dup_second_a", 64'(ed_a), 64'(DUP_EN));
    check("dup_mask_a",   mask_a, 64'h10);

    rst_n = 1'b0; tick(); rst_n = 1'b1;
    set_valid = 2'b11; set_idx = {6'd10, 6'd10}; tick(); idle();
    check("pair_dup_a",  64'(ed_a), 64'(DUP_EN));
    check("pair_mask_a", mask_a, 64'h400);
    check("pair_err_a",  64'(er_a), 64'd0);

    foreach (vecs[i]) begin
      set_valid = vecs[i].sv; set_idx = vecs[i].si; clr_valid = vecs[i].cv;
      clr_idx = vecs[i].ci; flush = vecs[i].fl; lookup_idx = vecs[i].lk;
      tick();
    end
    idle();
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/index_decoder_scoreboard.md
Name: index_decoder_scoreboard

Overview:
- Inverse companion to the priority encoder: converts index-valued events back into a WIDTH-bit registered bitmap.
- Used as a physical-register ready/free scoreboard. NUM_SET writeback/release ports set bits, one allocate port clears a bit, and flush clears or reloads the map.
- The registered mask feeds priority-encoder consumers (free-entry search). Registered count and lookup ports serve rename/issue logic.

Parameters:
- WIDTH, 64, number of tracked entries (any value ≥ 2, need not be a power of two).
- IDX_W, $clog2(WIDTH), index width (derived; not overridden).
- NUM_SET, 2, number of parallel set ports (1..4).
- RESET_ALL_SET, 0, if 1 the mask resets to all ones (free-list mode), else all zeros.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- set_valid  in  NUM_SET  per-port set request.
- set_idx  in  NUM_SET×IDX_W  per-port index to set (packed, port 0 in LSBs).
- clr_valid  in  1  clear request.
- clr_idx  in  IDX_W  index to clear.
- flush  in  1  synchronous flush to the reset pattern.
- lookup_idx  in  IDX_W  combinational query index.
- lookup_hit  out  1  mask[lookup_idx] from the registered mask; 0 if out of range.
- mask  out  WIDTH  registered bitmap.
- count  out  $clog2(WIDTH+1)  registered popcount of mask.
- err_range  out  1  sticky: a valid set or clear had index ≥ WIDTH.
- err_dup  out  1  sticky duplicate-operation flag (optional feature).

Behaviour:
- Reset (async assert, sync deassert by system):
  - mask = {WIDTH{RESET_ALL_SET}}.
  - count = RESET_ALL_SET ? WIDTH : 0.
  - err_range = 0, err_dup = 0.
- Decode: each valid request is decoded to a one-hot WIDTH vector. An index ≥ WIDTH decodes to all zeros, leaves mask unchanged and sets err_range.
- Update per cycle: next = (mask & ~clr_onehot) | OR(set_onehot[k]).
  - Clear is applied first, so set wins when set and clear target the same index.
- Multiple set ports targeting the same index: OR-merge, with no error.
- flush = 1 has the highest priority:
  - next mask = reset pattern; same-cycle set and clear are discarded.
  - err flags are NOT cleared by flush; only reset clears them.
- Latency: a request sampled at edge N is visible on mask, count and lookup_hit after edge N (1 cycle).
  - No combinational bypass from set/clr to lookup_hit.
- count is computed from next mask and registered, so it always equals popcount(mask) in the same cycle. Range 0..WIDTH inclusive, no wrap.
- No handshake back-pressure: every valid request is accepted every cycle.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight requests are lost.
- Idle (no valid, no flush): mask and count hold.

Optional Feature:
- Macro: SCOREBOARD_DUP_CHECK_EN.
- Defined: err_dup sets (sticky) when any of the following occurs without flush:
  - a valid set targets a bit already 1 in mask;
  - a valid clear targets a bit already 0;
  - two set ports name the same in-range index in one cycle.
  - Checks run against the registered mask, not next. Errors do not alter the update.
- Undefined: no check logic; err_dup tied to 0.

Decomposition:
- Shared package (scoreboard_pkg):
  - localparam defaults for WIDTH and NUM_SET;
  - typedef idx_t = logic [IDX_W-1:0];
  - typedef cnt_t for the count width.
- Sub-module onehot_decoder: combinational, WIDTH parameter; inputs idx, en; outputs onehot [WIDTH-1:0] and oor (out-of-range).
  - One instance per set port plus one for clear. It is the structural inverse of the 4-bit priority-encoder blocks.
- Popcount is an inline always_comb loop.

Test Plan:
- Reset, WIDTH=64, RESET_ALL_SET=0 → mask=0, count=0; with RESET_ALL_SET=1 → mask=all ones, count=64.
- set_valid=2'b11, set_idx={5,63} at edge N → after N: mask bits 5 and 63 set, count=2, lookup_idx=63 gives lookup_hit=1; before N, lookup_hit=0.
- Same cycle set_idx[0]=7 and clr_idx=7 on a cleared bit 7 → bit 7 = 1 (set wins). Then clr_idx=7 alone → bit 7 = 0, count decrements by 1.
- mask with bits 1,2,3 set, flush=1 with set_idx=9 the same cycle → mask=0, count=0, bit 9 not set; err flags unchanged.
- WIDTH=48, set_idx=50 → mask unchanged, err_range=1 and stays 1 through a flush, cleared only by rst_n=0.
- SCOREBOARD_DUP_CHECK_EN defined: set bit 4 twice on consecutive cycles → err_dup=1 after the second edge, mask bit 4 still 1. Macro undefined, same stimulus → err_dup=0.
